shift_add_mult_ctrl: RTL and testbench

- Control FSM for the team's serial shift-and-add multiplier.
- Sequences the multiplier right shift register, whose serial LSB output feeds `mult_bit`, together with the multiplicand left shift register and the product accumulator.
- Provides a start/ready/done handshake to the surrounding logic.
- Issues one-hot-in-time load, add and shift strobes; contains no datapath registers other than its own state and bit counter.

---
 rtl/shift_add_mult_ctrl.sv | 102 ++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for the serial shift-and-add multiplier: sequences load, per-bit
// evaluate/add and shift strobes, with a start/ready/done handshake and abort.
module shift_add_mult_ctrl #(
  parameter int WORD_LENGTH = 8,
  parameter bit EARLY_EXIT  = 1'b0,
  localparam int CW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          mult_bit,
  input  logic          mult_zero,
  output logic          ready,
  output logic          busy,
  output logic          load,
  output logic          acc_clear,
  output logic          acc_add,
  output logic          shift,
  output logic          done,
  output logic [CW-1:0] bit_index
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EVAL, S_SHIFT, S_DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(WORD_LENGTH - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    acc_clear = 1'b0;
    acc_add   = 1'b0;
    shift     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        load      = 1'b1;
        acc_clear = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_EVAL;
      end
      S_EVAL: begin
        busy = 1'b1;
        // Nothing left to add: skip the remaining iterations entirely.
        if (EARLY_EXIT && mult_zero) begin
          state_nxt = S_DONE;
        end else begin
          acc_add   = mult_bit;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (cnt == LAST) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt   = cnt + CW'(1);
          state_nxt = S_EVAL;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
    // Strobes of the aborted cycle still go out; only the sequencing is cancelled.
    if (abort && busy) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
  end

  assign bit_index = cnt;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: four instances (W=2, W=8, W=4, W=8 early-exit)
// each driving a behavioural shift-register/accumulator model; products scoreboarded.
module tb_shift_add_mult_ctrl;

  logic       clk, reset;
  logic [3:0] start, abort, mult_bit, mult_zero;
  logic [3:0] ready, busy, load, acc_clear, acc_add, shift, done;
  logic [0:0] bi0;
  logic [2:0] bi1;
  logic [1:0] bi2;
  logic [2:0] bi3;

  logic [15:0] opa    [4];
  logic [7:0]  opb    [4];
  logic [15:0] mcand  [4];
  logic [7:0]  mplier [4];
  logic [15:0] acc    [4];

  typedef struct {
    int          dut;
    logic [15:0] prod;
  } sb_t;
  sb_t sb[$];

  int n_chk, n_fail;
  logic [7:0] t1 [0:6];

  shift_add_mult_ctrl #(.WORD_LENGTH(2), .EARLY_EXIT(1'b0)) u_w2 (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
    .mult_bit(mult_bit[0]), .mult_zero(mult_zero[0]), .ready(ready[0]),
    .busy(busy[0]), .load(load[0]), .acc_clear(acc_clear[0]),
    .acc_add(acc_add[0]), .shift(shift[0]), .done(done[0]), .bit_index(bi0));

  shift_add_mult_ctrl #(.WORD_LENGTH(8), .EARLY_EXIT(1'b0)) u_w8 (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
    .mult_bit(mult_bit[1]), .mult_zero(mult_zero[1]), .ready(ready[1]),
    .busy(busy[1]), .load(load[1]), .acc_clear(acc_clear[1]),
    .acc_add(acc_add[1]), .shift(shift[1]), .done(done[1]), .bit_index(bi1));

  shift_add_mult_ctrl #(.WORD_LENGTH(4), .EARLY_EXIT(1'b0)) u_w4 (
    .clk(clk), .reset(reset), .start(start[2]), .abort(abort[2]),
    .mult_bit(mult_bit[2]), .mult_zero(mult_zero[2]), .ready(ready[2]),
    .busy(busy[2]), .load(load[2]), .acc_clear(acc_clear[2]),
    .acc_add(acc_add[2]), .shift(shift[2]), .done(done[2]), .bit_index(bi2));

  shift_add_mult_ctrl #(.WORD_LENGTH(8), .EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .reset(reset), .start(start[3]), .abort(abort[3]),
    .mult_bit(mult_bit[3]), .mult_zero(mult_zero[3]), .ready(ready[3]),
    .busy(busy[3]), .load(load[3]), .acc_clear(acc_clear[3]),
    .acc_add(acc_add[3]), .shift(shift[3]), .done(done[3]), .bit_index(bi3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: multiplicand shifts left, multiplier shifts right.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mcand[i]  <= '0;
        mplier[i] <= '0;
        acc[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          mcand[i]  <= opa[i];
          mplier[i] <= opb[i];
        end else if (shift[i]) begin
          mcand[i]  <= mcand[i] << 1;
          mplier[i] <= mplier[i] >> 1;
        end
        if (acc_clear[i])    acc[i] <= '0;
        else if (acc_add[i]) acc[i] <= acc[i] + mcand[i];
      end
    end
  end

  always_comb begin
    mult_bit  = '0;
    mult_zero = '0;
    for (int i = 0; i < 4; i++) begin
      mult_bit[i]  = mplier[i][0];
      mult_zero[i] = (mplier[i] == 8'd0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] outs(input int i);
    return {ready[i], busy[i], load[i], acc_clear[i], acc_add[i], shift[i], done[i]};
  endfunction

  function automatic int bidx(input int i);
    case (i)
      0: return int'(bi0);
      1: return int'(bi1);
      2: return int'(bi2);
      default: return int'(bi3);
    endcase
  endfunction

  // Called at the negedge where the LOAD cycle is visible (k=0).
  task automatic wait_done(input int i, output int k, output int nsh, output int nadd,
                           output logic last_add);
    k = 0; nsh = 0; nadd = 0; last_add = 1'b0;
    while (!done[i] && k < 60) begin
      nsh += int'(shift[i]);
      nadd += int'(acc_add[i]);
      last_add = acc_add[i];
      @(negedge clk);
      k++;
    end
  endtask

  // Scoreboard pop on done plus per-cycle strobe invariants.
  always @(negedge clk) begin : mon
    sb_t e;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        chk("strobe_excl", 32'((load[i] & acc_add[i]) | (load[i] & shift[i]) |
                               (acc_add[i] & shift[i])), 32'd0);
        chk("clr_wo_load", 32'(acc_clear[i] & ~load[i]), 32'd0);
        chk("ready_busy", 32'(ready[i] & busy[i]), 32'd0);
        if (done[i]) begin
          if (sb.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("sb_dut", 32'(i), 32'(e.dut));
            chk("product", 32'(acc[i]), 32'(e.prod));
          end
        end
      end
    end
  end

  initial begin
    int k, nsh, nadd, prev, nld;
    logic la, seen;
    t1[0] = 8'b0111_0000;  // LOAD
    t1[1] = 8'b0100_1000;  // EVAL, bit 0 = 1
    t1[2] = 8'b0100_0100;  // SHIFT
    t1[3] = 8'b0100_0001;  // EVAL, bit 1 = 0
    t1[4] = 8'b0100_0101;  // SHIFT
    t1[5] = 8'b0000_0011;  // DONE
    t1[6] = 8'b1000_0000;  // IDLE
    n_chk = 0; n_fail = 0;
    reset = 1'b1; start = '0; abort = '0;
    for (int i = 0; i < 4; i++) begin opa[i] = '0; opb[i] = '0; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_outs%0d", i), 32'(outs(i)), 32'b1000000);
      chk($sformatf("rst_bidx%0d", i), 32'(bidx(i)), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // W=2 cycle-by-cycle, multiplier bits 1,0
    opa[0] = 16'h5; opb[0] = 8'h1;
    start[0] = 1'b1; sb.push_back('{0, 16'h5});
    @(negedge clk);
    start[0] = 1'b0;
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("w2_c%0d", c), 32'({outs(0), bi0}), 32'(t1[c]));
      @(negedge clk);
    end

    // W=8, multiplicand 0x03, multiplier 0xB5
    opa[1] = 16'h3; opb[1] = 8'hB5;
    start[1] = 1'b1; sb.push_back('{1, 16'h021F});
    @(negedge clk);
    start[1] = 1'b0;
    wait_done(1, k, nsh, nadd, la);
    chk("w8_lat", 32'(k), 32'd17);
    chk("w8_shifts", 32'(nsh), 32'd8);
    chk("w8_adds", 32'(nadd), 32'd5);
    chk("w8_done_bidx", 32'(bi1), 32'd7);
    repeat (2) @(negedge clk);

    // W=4, abort on the second EVAL
    opa[2] = 16'h7; opb[2] = 8'h0F;
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_eval_add", 32'(acc_add[2]), 32'd1);
    chk("abort_eval_bidx", 32'(bi2), 32'd1);
    abort[2] = 1'b1;
    @(negedge clk);
    abort[2] = 1'b0;
    chk("abort_idle", 32'({ready[2], busy[2], bi2}), 32'b1000);
    seen = 1'b0;
    repeat (8) begin seen |= done[2]; @(negedge clk); end
    chk("abort_nodone", 32'(seen), 32'd0);
    start[2] = 1'b1; abort[2] = 1'b1; sb.push_back('{2, 16'd105});
    @(negedge clk);
    start[2] = 1'b0; abort[2] = 1'b0;
    chk("start_beats_abort", 32'(load[2]), 32'd1);
    wait_done(2, k, nsh, nadd, la);
    chk("w4_lat", 32'(k), 32'd9);
    repeat (2) @(negedge clk);

    // Early exit, multiplier 0x03: done after two shifts
    opa[3] = 16'h9; opb[3] = 8'h03;
    start[3] = 1'b1; sb.push_back('{3, 16'd27});
    @(negedge clk);
    start[3] = 1'b0;
    wait_done(3, k, nsh, nadd, la);
    chk("ee_lat", 32'(k), 32'd6);
    chk("ee_shifts", 32'(nsh), 32'd2);
    chk("ee_adds", 32'(nadd), 32'd2);
    chk("ee_term_add", 32'(la), 32'd0);
    repeat (2) @(negedge clk);

    // start held high on W=2: back-to-back operations
    opa[0] = 16'h6; opb[0] = 8'h3;
    start[0] = 1'b1;
    prev = -1; nld = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (load[0]) begin
        sb.push_back('{0, 16'd18});
        if (prev >= 0) chk("hold_interval", 32'(c - prev), 32'd7);
        prev = c; nld++;
      end
    end
    start[0] = 1'b0;
    chk("hold_loads", 32'(nld), 32'd4);
    repeat (10) @(negedge clk);

    // Asynchronous reset mid-SHIFT on W=8
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_shift", 32'(shift[1]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_outs", 32'(outs(1)), 32'b1000000);
    chk("async_rst_bidx", 32'(bi1), 32'd0);
    @(negedge clk);
    reset = 1'b0; start[1] = 1'b1; sb.push_back('{1, 16'h021F});
    @(negedge clk);
    start[1] = 1'b0;
    chk("post_rst_load", 32'(load[1]), 32'd1);
    wait_done(1, k, nsh, nadd, la);
    chk("post_rst_lat", 32'(k), 32'd17);
    repeat (3) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
